// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, PC increment and fetch FSM states shared by the fetch unit.
package fetch_pkg;
   localparam int PC_W    = 16;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry instruction/PC holding register between fetch and decode.
// A flush always wins; a load refills the entry even while it is being consumed.
module fetch_buffer #(
   parameter int PC_W    = fetch_pkg::PC_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               flush,
   input  logic               ready,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [PC_W-1:0]    pc_plus4_in,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_plus4
);

   // valid: flush, then refill, then consumption by decode
   always_ff @(posedge clk) begin
      if (!rst_n)      valid <= 1'b0;
      else if (flush)  valid <= 1'b0;
      else if (load)   valid <= 1'b1;
      else if (ready)  valid <= 1'b0;
   end

   // payload changes only on a refill, so it is stable while decode stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr    <= '0;
         pc       <= '0;
         pc_plus4 <= '0;
      end else if (load && !flush) begin
         instr    <= instr_in;
         pc       <= pc_in;
         pc_plus4 <= pc_plus4_in;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: sequential instruction fetch with redirect and request draining.
// Build option: define FETCH_ALIGN_CHECK_EN to get a sticky misaligned-redirect flag;
// otherwise target bits [1:0] are dropped silently and fetch_misalign is 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; loads RESET_PC and moves on, redirects ignored
// ST_FETCH | issuing requests at pc, loading acked data into the buffer
// ST_DRAIN | redirect arrived with a request in flight; wait for its ack,
//          | drop the data, then resume at the pending target
module pc_fetch_unit #(
   parameter int              PC_W     = fetch_pkg::PC_W,
   parameter int              INSTR_W  = fetch_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'h0000)
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic [PC_W-1:0]    if_pc_plus4,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_target,
   output logic               fetch_misalign
);
   import fetch_pkg::*;

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt, tgt, tgt_nxt;
   logic [PC_W-1:0] pc_inc, redirect_aligned;
   logic            outstanding, outstanding_nxt;
   logic            redirect_take, ack_take, buf_load;

   assign redirect_aligned = redirect_target & ~PC_W'(3);
   assign pc_inc           = pc + PC_W'(PC_STEP);
   assign redirect_take    = redirect_valid && (state != ST_IDLE);

   // a raised request is held until acked, regardless of decode or redirect
   assign imem_req  = outstanding ||
                      ((state == ST_FETCH) && (!if_valid || if_ready) && !redirect_valid);
   assign imem_addr = pc;
   assign ack_take  = imem_req && imem_ack;
   assign buf_load  = ack_take && (state == ST_FETCH) && !redirect_valid;

   // state, pc, pending redirect target and in-flight flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         tgt         <= '0;
         outstanding <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         tgt         <= tgt_nxt;
         outstanding <= outstanding_nxt;
      end
   end

   // next-state: redirect first, then ack, then holding a fresh request
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      tgt_nxt         = tgt;
      outstanding_nxt = outstanding;
      case (state)
         ST_IDLE: begin
            state_nxt       = ST_FETCH;
            pc_nxt          = RESET_PC;
            outstanding_nxt = 1'b0;
         end
         ST_FETCH: begin
            if (redirect_valid) begin
               if (outstanding && !imem_ack) begin
                  state_nxt = ST_DRAIN;
                  tgt_nxt   = redirect_aligned;
               end else begin
                  pc_nxt          = redirect_aligned;
                  outstanding_nxt = 1'b0;
               end
            end else if (ack_take) begin
               pc_nxt          = pc_inc;
               outstanding_nxt = 1'b0;
            end else if (imem_req) begin
               outstanding_nxt = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) tgt_nxt = redirect_aligned;
            if (imem_ack) begin
               state_nxt       = ST_FETCH;
               pc_nxt          = redirect_valid ? redirect_aligned : tgt;
               outstanding_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   fetch_buffer #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_buffer (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (buf_load),
      .flush       (redirect_take),
      .ready       (if_ready),
      .instr_in    (imem_rdata),
      .pc_in       (pc),
      .pc_plus4_in (pc_inc),
      .valid       (if_valid),
      .instr       (if_instr),
      .pc          (if_pc),
      .pc_plus4    (if_pc_plus4)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   // sticky until reset once any accepted redirect is misaligned
   always_ff @(posedge clk) begin
      if (!rst_n)
         fetch_misalign <= 1'b0;
      else if (redirect_take && (redirect_target[1:0] != 2'b00))
         fetch_misalign <= 1'b1;
   end
`else
   assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_pc_fetch_unit;
   localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus4;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic        fetch_misalign;

   pc_fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_misalign  (fetch_misalign)
   );

   always #5 clk = ~clk;

   // reference model: fetch stream as a next address, an in-flight flag,
   // a pending redirect, and a queue of buffered instructions
   typedef struct {
      logic [31:0] instr;
      logic [15:0] pc;
   } entry_t;

   entry_t      buf_q[$];
   bit          m_started, m_in_flight, m_drop, m_misalign;
   logic [15:0] m_next_pc, m_redir_pc;
   bit          exp_req;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit rn, input bit ack, input bit rdy, input bit redir,
                        input logic [15:0] tgt);
      rst_n           = rn;
      imem_ack        = ack;
      if_ready        = rdy;
      redirect_valid  = redir;
      redirect_target = tgt;
      imem_rdata      = $urandom;
   endtask

   // compare DUT outputs against the model mid-cycle
   task automatic settle();
      #2;
      exp_req = m_in_flight || (m_started && (buf_q.size() == 0 || if_ready) && !redirect_valid);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_next_pc));
      check("if_valid", 32'(if_valid), 32'(buf_q.size() != 0));
      if (buf_q.size() != 0) begin
         check("if_instr", if_instr, buf_q[0].instr);
         check("if_pc", 32'(if_pc), 32'(buf_q[0].pc));
         check("if_pc_plus4", 32'(if_pc_plus4), 32'(16'(buf_q[0].pc + 16'd4)));
      end
      check("fetch_misalign", 32'(fetch_misalign), 32'(m_misalign));
   endtask

   // advance the model across the clock edge using this cycle's inputs
   task automatic tick();
      bit acc;
      acc = exp_req && imem_ack;
      @(posedge clk);
      if (!rst_n) begin
         buf_q.delete();
         m_started   = 1'b0;
         m_in_flight = 1'b0;
         m_drop      = 1'b0;
         m_misalign  = 1'b0;
         m_next_pc   = RESET_PC;
      end else if (!m_started) begin
         m_started = 1'b1;
         m_next_pc = RESET_PC;
      end else begin
         if (buf_q.size() != 0 && if_ready) void'(buf_q.pop_front());
         if (redirect_valid) begin
            buf_q.delete();
            if (ALIGN_EN && redirect_target[1:0] != 2'b00) m_misalign = 1'b1;
            if (m_in_flight && !acc) begin
               m_drop     = 1'b1;
               m_redir_pc = redirect_target & 16'hFFFC;
            end else begin
               m_in_flight = 1'b0;
               m_drop      = 1'b0;
               m_next_pc   = redirect_target & 16'hFFFC;
            end
         end else if (acc) begin
            if (m_drop) begin
               m_next_pc = m_redir_pc;
            end else begin
               buf_q.push_back('{imem_rdata, m_next_pc});
               m_next_pc = m_next_pc + 16'd4;
            end
            m_in_flight = 1'b0;
            m_drop      = 1'b0;
         end else if (exp_req) begin
            m_in_flight = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      exp_req = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();

      // reset holds everything cleared, redirect ignored
      repeat (2) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
         settle();
         check("rst_instr", if_instr, 32'h0);
         check("rst_pc", 32'(if_pc), 32'h0);
         check("rst_pc_plus4", 32'(if_pc_plus4), 32'h0);
         tick();
      end

      // release, ack tied high: 0,4,8,12 back to back
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("boot_idle_req", 32'(imem_req), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
         settle();
         check("seq_addr", 32'(imem_addr), 32'(i * 4));
         check("seq_valid", 32'(if_valid), 32'(i > 0));
         if (i > 0) check("seq_if_pc", 32'(if_pc), 32'((i - 1) * 4));
         tick();
      end

      // decode stall: buffer holds 12, no request, no advance
      repeat (3) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
         settle();
         check("stall_req", 32'(imem_req), 32'h0);
         check("stall_if_pc", 32'(if_pc), 32'h000C);
         check("stall_addr", 32'(imem_addr), 32'h0010);
         tick();
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("resume_req", 32'(imem_req), 32'h1);
      tick();

      // redirect to 0x40 while 0x10 is waiting; ack two cycles later is dropped
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040);
      settle();
      check("drain_req", 32'(imem_req), 32'h1);
      check("drain_addr", 32'(imem_addr), 32'h0010);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("drain_hold_addr", 32'(imem_addr), 32'h0010);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("drain_dropped", 32'(if_valid), 32'h0);
      check("drain_new_addr", 32'(imem_addr), 32'h0040);
      tick();

      // wrap at the top of the address space
      drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFC);
      settle();
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("wrap_addr", 32'(imem_addr), 32'hFFFC);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("wrap_if_pc", 32'(if_pc), 32'hFFFC);
      check("wrap_plus4", 32'(if_pc_plus4), 32'h0000);
      check("wrap_next_addr", 32'(imem_addr), 32'h0000);
      tick();

      // misaligned redirect
      drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042);
      settle();
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      settle();
      check("misalign_addr", 32'(imem_addr), 32'h0040);
      check("misalign_flag", 32'(fetch_misalign), 32'(ALIGN_EN));
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("misalign_sticky", 32'(fetch_misalign), 32'(ALIGN_EN));
      tick();

      // random traffic
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) != 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 16'($urandom));
         settle();
         tick();
      end

      // reset with a request in flight; late ack ignored
      repeat (3) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
         settle();
         tick();
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("pre_rst_req", 32'(imem_req), 32'h1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("rst_req_low", 32'(imem_req), 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      settle();
      check("late_ack_valid", 32'(if_valid), 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("post_rst_req", 32'(imem_req), 32'h1);
      check("post_rst_addr", 32'(imem_addr), 32'(RESET_PC));
      check("post_rst_misalign", 32'(fetch_misalign), 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter PC_W, default 16, is the PC width.
REQ-003 Parameter INSTR_W, default 32, is the instruction width.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Ports SHALL be:
clk  in  1  sole clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  fetch byte address
imem_ack  in  1  memory accepted request, imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
if_valid  out  1  instruction available to decode
if_ready  in  1  decode consumes the instruction this cycle
if_instr  out  INSTR_W  buffered instruction
if_pc  out  PC_W  address of if_instr
if_pc_plus4  out  PC_W  if_pc+4, mod 2^PC_W
redirect_valid  in  1  branch/jump taken
redirect_target  in  PC_W  new fetch address
fetch_misalign  out  1  sticky misaligned-redirect flag

Function
REQ-006 FSM states are IDLE, FETCH and DRAIN; the reset state is IDLE.
REQ-007 IDLE SHALL go to FETCH on the first cycle after rst_n is sampled high, with pc=RESET_PC.
REQ-008 imem_req SHALL be (state==FETCH) && (!if_valid || if_ready) && !redirect_valid.
REQ-009 imem_addr SHALL equal pc.
REQ-010 Once raised, imem_req and imem_addr SHALL hold stable until imem_ack, even if if_ready falls.
REQ-011 On imem_ack in FETCH without redirect, the unit SHALL load if_instr=imem_rdata, if_pc=pc and if_pc_plus4=pc+4, set if_valid on the next edge, and set pc to pc+4.
REQ-012 Ack-to-if_valid latency SHALL be 1 cycle; with single-cycle ack and if_ready held high, throughput SHALL be one instruction per cycle.
REQ-013 if_valid SHALL clear on the edge after if_valid && if_ready unless a new ack loads the buffer in the same cycle.
REQ-014 The buffer contents SHALL be stable while if_valid && !if_ready.
REQ-015 PC arithmetic SHALL wrap modulo 2^PC_W, so 16'hFFFC+4 gives 16'h0000.
REQ-016 redirect_valid SHALL have priority over all other events: if_valid clears on the next edge and pc loads redirect_target.
REQ-017 Redirect with no request outstanding, or with imem_ack in the same cycle: the unit SHALL drop any acked data and stay in or enter FETCH at the target.
REQ-018 Redirect while a request is outstanding without ack: the unit SHALL enter DRAIN, keep imem_req and the old imem_addr until ack, discard that data, then enter FETCH at the target.
REQ-019 A second redirect during DRAIN SHALL overwrite the pending target.
REQ-020 redirect_valid in IDLE or during reset SHALL be ignored.

Reset
REQ-021 While rst_n=0 at an edge: state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fetch_misalign=0.
REQ-022 imem_req=0 throughout reset.
REQ-023 Reset asserted mid-request SHALL abandon the request; imem_req SHALL be 0 in the cycle after reset is sampled, and a late ack SHALL be ignored.

Configuration
REQ-024 Macro FETCH_ALIGN_CHECK_EN defined: a redirect_target with bits[1:0]!=0 SHALL set fetch_misalign, which stays set until reset; pc loads target with bits[1:0] cleared.
REQ-025 Macro FETCH_ALIGN_CHECK_EN undefined: target bits[1:0] are cleared silently and fetch_misalign is tied 0.

Structure
REQ-026 Shared package fetch_pkg SHALL hold PC_W, INSTR_W, PC_STEP=4 and the FSM state enum.
REQ-027 One sub-module, fetch_buffer, is natural; it SHALL hold the one-entry if_instr/if_pc/if_pc_plus4 register with valid/ready control.

Verification
REQ-028 Reset release, imem_ack tied 1, if_ready=1 -> imem_addr 0,4,8,12 on consecutive cycles; if_valid from the second cycle; if_pc_plus4=if_pc+4.
REQ-029 if_ready=0 for 3 cycles with if_valid=1 -> if_instr/if_pc stable, imem_req=0, no PC advance; fetch resumes the cycle if_ready=1.
REQ-030 Redirect to 16'h0040 while the request to 16'h0010 is waiting, ack after 2 cycles -> old data dropped, if_valid stays 0, next imem_addr=16'h0040.
REQ-031 pc=16'hFFFC, acked -> if_pc_plus4=16'h0000 and next imem_addr=16'h0000.
REQ-032 Redirect to 16'h0042 with FETCH_ALIGN_CHECK_EN -> fetch_misalign=1 and sticky, imem_addr=16'h0040; without the macro -> fetch_misalign=0.
REQ-033 rst_n low during an outstanding request -> imem_req=0 next cycle, late ack ignored; after release the first imem_addr=RESET_PC.
